// File: rtl/mixer_pkg.sv
// Shared types and helpers for the multichannel mixer and its gain ramps.
package mixer_pkg;

    // Widest signed value the saturation check accepts; the accumulator must fit.
    localparam int SAT_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUTPUT
    } state_t;

    // Which rail, if any, a wide value crosses when narrowed to the sample width.
    typedef struct packed {
        logic pos;
        logic neg;
    } sat_t;

    // Unity gain in unsigned Q1.(gainsize-1).
    function automatic logic [63:0] unity_gain(input int gainsize);
        return 64'd1 << (gainsize - 1);
    endfunction

    // Accumulator width that holds CHANNELS full-scale products without wrapping.
    function automatic int acc_width(input int bitsize, input int gainsize, input int channels);
        return bitsize + gainsize + $clog2(channels) + 1;
    endfunction

    // Classify a wide signed value against the signed bitsize range.
    function automatic sat_t sat_check(input logic signed [SAT_W-1:0] value, input int bitsize);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_t r;
        max_v = (SAT_W'(1) << (bitsize - 1)) - SAT_W'(1);
        min_v = -max_v - SAT_W'(1);
        r.pos = (value > max_v);
        r.neg = (value < min_v);
        return r;
    endfunction

endpackage

// File: rtl/gain_ramp.sv
// Per-channel current gain; approaches the live target by at most RAMPSTEP per enable.
module gain_ramp #(
    parameter int GAINSIZE = 24,
    parameter int RAMPSTEP = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [GAINSIZE-1:0] target,
    output logic [GAINSIZE-1:0] cur
);

    localparam logic [GAINSIZE-1:0] STEP = GAINSIZE'(RAMPSTEP);

    logic [GAINSIZE-1:0] diff;
    logic [GAINSIZE-1:0] next_gain;

    // Next gain: jump straight to target, or move toward it by min(STEP, |diff|).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        next_gain = target;
        diff      = '0;
        if (RAMPSTEP != 0) begin
            if (target >= cur) begin
                diff      = target - cur;
                next_gain = (diff > STEP) ? cur + STEP : target;
            end else begin
                diff      = cur - target;
                next_gain = (diff > STEP) ? cur - STEP : target;
            end
        end
    end

    // Gain register; starts muted so every channel fades in after reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (reset) begin
            cur <= '0;
        end else if (en) begin
            cur <= next_gain;
        end
    end

endmodule

// File: rtl/multichannel_mixer.sv
// N-channel mixer: snapshot per frame, one shared MAC over channels, saturated output.
module multichannel_mixer
    import mixer_pkg::*;
#(
    parameter int BITSIZE  = 24,
    parameter int CHANNELS = 4,
    parameter int GAINSIZE = 24,
    parameter int RAMPSTEP = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_strobe,
    input  logic [CHANNELS*BITSIZE-1:0]  in,
    input  logic [CHANNELS*GAINSIZE-1:0] gain,
    input  logic                         clip_clear,
    output logic [BITSIZE-1:0]           out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic                         clip
);

    localparam int ACC_W  = acc_width(BITSIZE, GAINSIZE, CHANNELS);
    localparam int PROD_W = BITSIZE + GAINSIZE + 1;
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [BITSIZE-1:0] OUT_MAX  = {1'b0, {(BITSIZE-1){1'b1}}};
    localparam logic [BITSIZE-1:0] OUT_MIN  = {1'b1, {(BITSIZE-1){1'b0}}};

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc;
    logic signed [BITSIZE-1:0]  snap [CHANNELS];
    logic [GAINSIZE-1:0]        cur_gain [CHANNELS];
    logic [CHANNELS-1:0]        ramp_en;

    logic signed [BITSIZE-1:0]  snap_sel;
    logic [GAINSIZE-1:0]        gain_sel;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    shifted;
    sat_t                       sat;
    logic [BITSIZE-1:0]         narrowed;

    // One ramp per channel, stepped only in the MAC cycle that reads that channel,
    // so the MAC sees the pre-update gain and the new gain applies next frame.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign ramp_en[i] = (state == ST_MAC) && (idx == IDX_W'(i));

        gain_ramp #(
            .GAINSIZE (GAINSIZE),
            .RAMPSTEP (RAMPSTEP)
        ) u_gain_ramp (
            .clk    (clk),
            .reset  (reset),
            .en     (ramp_en[i]),
            .target (gain[i*GAINSIZE +: GAINSIZE]),
            .cur    (cur_gain[i])
        );
    end

    // Shared multiplier: signed sample times zero-extended unsigned gain.
    assign snap_sel = snap[idx];
    assign gain_sel = cur_gain[idx];
    assign prod     = PROD_W'(snap_sel) * PROD_W'($signed({1'b0, gain_sel}));

    // Drop the Q fraction with an arithmetic shift (floor), then check the rails.
    assign shifted  = acc >>> (GAINSIZE - 1);
    assign sat      = sat_check(SAT_W'(shifted), BITSIZE);

    // Narrow to the sample width, clamping to whichever rail was crossed.
    always_comb begin
        narrowed = shifted[BITSIZE-1:0];
        if (sat.pos) begin
            narrowed = OUT_MAX;
        end else if (sat.neg) begin
            narrowed = OUT_MIN;
        end
    end

    // Frame sequencer: IDLE -> MAC (one channel per cycle) -> OUTPUT -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            clip      <= 1'b0;
            // NOTE: the snapshot is a handful of registers, so it is reset with the rest
            // instead of being left to power-up garbage like a RAM would be.
            for (int i = 0; i < CHANNELS; i++) begin
                snap[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            if (clip_clear) begin
                clip <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    busy <= sample_strobe;
                    if (sample_strobe) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            snap[i] <= in[i*BITSIZE +: BITSIZE];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= ST_MAC;
                    end
                end

                ST_MAC: begin
                    overrun <= sample_strobe;
                    acc     <= acc + ACC_W'(prod);
                    if (idx == LAST_IDX) begin
                        state <= ST_OUTPUT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                ST_OUTPUT: begin
                    overrun   <= sample_strobe;
                    out       <= narrowed;
                    out_valid <= 1'b1;
                    // A new clip overrides a simultaneous clip_clear.
                    if (sat.pos || sat.neg) begin
                        clip <= 1'b1;
                    end
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multichannel_mixer.sv
// Self-checking bench: an immediate-gain mixer and a ramping mixer driven in lockstep,
// each compared against an arithmetic reference model of the mixing rules.
module tb_multichannel_mixer;

    localparam int     BITSIZE  = 24;
    localparam int     CHANNELS = 2;
    localparam int     GAINSIZE = 24;
    localparam int     RAMP_B   = 'h100000;
    localparam longint OUT_MAX  = (longint'(1) << (BITSIZE - 1)) - 1;
    localparam longint OUT_MIN  = -(longint'(1) << (BITSIZE - 1));

    logic clk = 1'b0;
    logic reset;
    logic sample_strobe;
    logic clip_clear;
    logic [CHANNELS*BITSIZE-1:0]  in_bus;
    logic [CHANNELS*GAINSIZE-1:0] gain_bus;

    logic [BITSIZE-1:0] out_s       [2];
    logic               out_valid_s [2];
    logic               busy_s      [2];
    logic               overrun_s   [2];
    logic               clip_s      [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: index 0 = immediate gains, 1 = ramped gains.
    longint smp    [CHANNELS];
    longint tgt    [CHANNELS];
    longint cur_m  [2][CHANNELS];
    longint out_m  [2];
    bit     clip_m [2];
    longint step_m [2] = '{0, RAMP_B};

    always #5 clk = ~clk;

    multichannel_mixer #(
        .BITSIZE (BITSIZE), .CHANNELS (CHANNELS), .GAINSIZE (GAINSIZE), .RAMPSTEP (0)
    ) u_imm (
        .clk (clk), .reset (reset), .sample_strobe (sample_strobe),
        .in (in_bus), .gain (gain_bus), .clip_clear (clip_clear),
        .out (out_s[0]), .out_valid (out_valid_s[0]), .busy (busy_s[0]),
        .overrun (overrun_s[0]), .clip (clip_s[0])
    );

    multichannel_mixer #(
        .BITSIZE (BITSIZE), .CHANNELS (CHANNELS), .GAINSIZE (GAINSIZE), .RAMPSTEP (RAMP_B)
    ) u_ramp (
        .clk (clk), .reset (reset), .sample_strobe (sample_strobe),
        .in (in_bus), .gain (gain_bus), .clip_clear (clip_clear),
        .out (out_s[1]), .out_valid (out_valid_s[1]), .busy (busy_s[1]),
        .overrun (overrun_s[1]), .clip (clip_s[1])
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic longint to_s(input logic [BITSIZE-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < CHANNELS; ch++) cur_m[d][ch] = 0;
            out_m[d]  = 0;
            clip_m[d] = 1'b0;
        end
    endfunction

    // One frame of the mixing rules: weighted sum, floor by 2^(GAINSIZE-1), clamp,
    // then each current gain moves toward its target for use in the next frame.
    function automatic void model_frame(input bit clear_held);
        for (int d = 0; d < 2; d++) begin
            longint sum = 0;
            longint q;
            longint diff;
            bit     hit = 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) sum += smp[ch] * cur_m[d][ch];
            q = sum >>> (GAINSIZE - 1);
            if (q > OUT_MAX) begin
                q = OUT_MAX; hit = 1'b1;
            end else if (q < OUT_MIN) begin
                q = OUT_MIN; hit = 1'b1;
            end
            out_m[d]  = q;
            clip_m[d] = clear_held ? hit : (clip_m[d] | hit);
            for (int ch = 0; ch < CHANNELS; ch++) begin
                diff = tgt[ch] - cur_m[d][ch];
                if (step_m[d] == 0 || (diff <= step_m[d] && diff >= -step_m[d]))
                    cur_m[d][ch] = tgt[ch];
                else if (diff > 0)
                    cur_m[d][ch] += step_m[d];
                else
                    cur_m[d][ch] -= step_m[d];
            end
        end
    endfunction

    task automatic drive_inputs();
        for (int ch = 0; ch < CHANNELS; ch++) begin
            in_bus[ch*BITSIZE +: BITSIZE]    = smp[ch][BITSIZE-1:0];
            gain_bus[ch*GAINSIZE +: GAINSIZE] = tgt[ch][GAINSIZE-1:0];
        end
    endtask

    // Full frame from a negedge in IDLE; checks exact latency, value, clip and busy.
    task automatic run_frame(input string tag, input bit clear_held);
        drive_inputs();
        clip_clear    = clear_held;
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        model_frame(clear_held);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s.busy_start.d%0d", tag, d), 64'(busy_s[d]), 64'd1);
            check($sformatf("%s.overrun.d%0d", tag, d), 64'(overrun_s[d]), 64'd0);
        end
        for (int j = 1; j <= CHANNELS + 1; j++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                check($sformatf("%s.valid_k%0d.d%0d", tag, j, d), 64'(out_valid_s[d]),
                      64'(j == CHANNELS + 1));
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s.out.d%0d", tag, d), 64'(out_s[d]), 64'(out_m[d][BITSIZE-1:0]));
            check($sformatf("%s.clip.d%0d", tag, d), 64'(clip_s[d]), 64'(clip_m[d]));
            check($sformatf("%s.busy_out.d%0d", tag, d), 64'(busy_s[d]), 64'd1);
        end
        clip_clear = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s.busy_end.d%0d", tag, d), 64'(busy_s[d]), 64'd0);
            check($sformatf("%s.valid_end.d%0d", tag, d), 64'(out_valid_s[d]), 64'd0);
        end
    endtask

    task automatic pulse_clear(input string tag);
        clip_clear = 1'b1;
        @(negedge clk);
        clip_clear = 1'b0;
        for (int d = 0; d < 2; d++) begin
            clip_m[d] = 1'b0;
            check($sformatf("%s.clip.d%0d", tag, d), 64'(clip_s[d]), 64'd0);
        end
    endtask

    task automatic set_frame(input logic [BITSIZE-1:0] s0, input logic [BITSIZE-1:0] s1,
                             input longint g0, input longint g1);
        smp[0] = to_s(s0);
        smp[1] = to_s(s1);
        tgt[0] = g0;
        tgt[1] = g1;
    endtask

    initial begin
        reset         = 1'b1;
        sample_strobe = 1'b0;
        clip_clear    = 1'b0;
        in_bus        = '0;
        gain_bus      = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst.out.d%0d", d), 64'(out_s[d]), 64'd0);
            check($sformatf("rst.valid.d%0d", d), 64'(out_valid_s[d]), 64'd0);
            check($sformatf("rst.busy.d%0d", d), 64'(busy_s[d]), 64'd0);
            check($sformatf("rst.overrun.d%0d", d), 64'(overrun_s[d]), 64'd0);
            check($sformatf("rst.clip.d%0d", d), 64'(clip_s[d]), 64'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Basic scaling: first frame is muted, second gives 0x100000 * 0.5.
        set_frame(24'h100000, 24'h000000, 'h400000, 'h800000);
        run_frame("basic1", 1'b0);
        check("basic1.lit", 64'(out_s[0]), 64'h000000);
        run_frame("basic2", 1'b0);
        check("basic2.lit", 64'(out_s[0]), 64'h080000);

        // Positive saturation, then clip_clear coinciding with a new clip.
        set_frame(24'h7FFFFF, 24'h7FFFFF, 'h800000, 'h800000);
        for (int f = 0; f < 9; f++) run_frame($sformatf("pos%0d", f), 1'b0);
        check("pos.lit.d0", 64'(out_s[0]), 64'h7FFFFF);
        check("pos.lit.d1", 64'(out_s[1]), 64'h7FFFFF);
        check("pos.clip.lit", 64'(clip_s[0]), 64'd1);
        run_frame("pos_setwins", 1'b1);
        pulse_clear("pos_clear");

        // Negative saturation.
        set_frame(24'h800000, 24'h800000, 'h800000, 'h800000);
        run_frame("neg0", 1'b0);
        run_frame("neg1", 1'b0);
        check("neg.lit.d0", 64'(out_s[0]), 64'h800000);
        pulse_clear("neg_clear");

        // -1 * 0.5 floors to -1.
        set_frame(24'hFFFFFF, 24'h000000, 'h400000, 'h800000);
        for (int f = 0; f < 5; f++) run_frame($sformatf("trunc%0d", f), 1'b0);
        check("trunc.lit.d0", 64'(out_s[0]), 64'hFFFFFF);
        check("trunc.lit.d1", 64'(out_s[1]), 64'hFFFFFF);

        // Ramp up from mute, then back down.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        set_frame(24'h100000, 24'h000000, 'h800000, 'h000000);
        for (int f = 0; f < 10; f++) run_frame($sformatf("rampup%0d", f), 1'b0);
        check("rampup.lit", 64'(out_s[1]), 64'h100000);
        tgt[0] = 0;
        run_frame("rampdn0", 1'b0);
        run_frame("rampdn1", 1'b0);
        check("rampdn.lit", 64'(out_s[1]), 64'h0E0000);
        for (int f = 2; f < 10; f++) run_frame($sformatf("rampdn%0d", f), 1'b0);
        check("rampdn.zero.lit", 64'(out_s[1]), 64'h000000);

        // Overrun: second strobe with changed samples must be ignored.
        set_frame(24'h123456, 24'hFF0000, 'h800000, 'h600000);
        run_frame("ovr_settle", 1'b0);
        drive_inputs();
        sample_strobe = 1'b1;
        @(negedge clk);
        model_frame(1'b0);
        for (int ch = 0; ch < CHANNELS; ch++) in_bus[ch*BITSIZE +: BITSIZE] = BITSIZE'($urandom);
        @(negedge clk);
        sample_strobe = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("ovr.pulse.d%0d", d), 64'(overrun_s[d]), 64'd1);
            check($sformatf("ovr.busy.d%0d", d), 64'(busy_s[d]), 64'd1);
        end
        for (int j = 2; j <= CHANNELS + 1; j++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("ovr.valid_k%0d.d%0d", j, d), 64'(out_valid_s[d]),
                      64'(j == CHANNELS + 1));
                check($sformatf("ovr.pulse_k%0d.d%0d", j, d), 64'(overrun_s[d]), 64'd0);
            end
        end
        for (int d = 0; d < 2; d++)
            check($sformatf("ovr.out.d%0d", d), 64'(out_s[d]), 64'(out_m[d][BITSIZE-1:0]));
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("ovr.valid_end.d%0d", d), 64'(out_valid_s[d]), 64'd0);

        // Random frames, sometimes holding clip_clear through the frame.
        for (int f = 0; f < 24; f++) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                smp[ch] = to_s(BITSIZE'($urandom));
                tgt[ch] = longint'($urandom_range(0, (1 << GAINSIZE) - 1));
            end
            run_frame($sformatf("rnd%0d", f), ($urandom_range(0, 3) == 0));
        end

        // Reset mid-MAC aborts the frame.
        set_frame(24'h200000, 24'h300000, 'h700000, 'h500000);
        run_frame("pre_rst", 1'b0);
        drive_inputs();
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midrst.out.d%0d", d), 64'(out_s[d]), 64'd0);
            check($sformatf("midrst.busy.d%0d", d), 64'(busy_s[d]), 64'd0);
        end
        reset = 1'b0;
        for (int j = 0; j < CHANNELS + 2; j++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                check($sformatf("midrst.novalid%0d.d%0d", j, d), 64'(out_valid_s[d]), 64'd0);
        end
        run_frame("post_rst0", 1'b0);
        check("post_rst.lit", 64'(out_s[0]), 64'h000000);
        run_frame("post_rst1", 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
